// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: opcodes, funct3
// values and the 4-bit ALU operation encoding.
package alu_pkg;

    localparam int XLEN = 32;

    // Major opcodes, instruction bits [6:0]
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 values for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // ALU operation encoding; codes 11..14 are unused and behave like XXX
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRA    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_COPY_B = 4'd10,
        ALU_XXX    = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction-field decoder: opcode/funct3/bit30 -> ALU op.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct_i,
    input  logic       add_rshift_type_i,
    output alu_op_e    alu_op_o
);

    logic is_rtype;

    // Only register-register ADD can become SUB; immediate ADD never does
    assign is_rtype = (opcode_i == OPC_RTYPE);

    // Decode the operation from the instruction fields
    always_comb begin
        alu_op_o = ALU_XXX;
        case (opcode_i)
            OPC_RTYPE, OPC_ITYPE: begin
                case (funct_i)
                    F3_ADD_SUB: alu_op_o = (is_rtype && add_rshift_type_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     alu_op_o = ALU_SLL;
                    F3_SLT:     alu_op_o = ALU_SLT;
                    F3_SLTU:    alu_op_o = ALU_SLTU;
                    F3_XOR:     alu_op_o = ALU_XOR;
                    F3_SRL_SRA: alu_op_o = add_rshift_type_i ? ALU_SRA : ALU_SRL;
                    F3_OR:      alu_op_o = ALU_OR;
                    F3_AND:     alu_op_o = ALU_AND;
                    default:    alu_op_o = ALU_XXX;
                endcase
            end
            OPC_LUI:    alu_op_o = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE:
                        alu_op_o = ALU_ADD;
            default:    alu_op_o = ALU_XXX;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// RV32I execute-stage ALU: decoder, combinational datapath and one
// enable-gated registered copy of the result.
module alu_core
    import alu_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct,
    input  logic            add_rshift_type,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            en,
    output logic [3:0]      ALUop,
    output logic [XLEN-1:0] Out,
    output logic [XLEN-1:0] Out_q
);

    alu_op_e         alu_op;
    logic [4:0]      shamt;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] result_q;

    alu_op_decoder u_dec (
        .opcode_i          (opcode),
        .funct_i           (funct),
        .add_rshift_type_i (add_rshift_type),
        .alu_op_o          (alu_op)
    );

    assign ALUop = alu_op;
    // Only the low five bits of B form the shift amount
    assign shamt = B[4:0];

    // Datapath: apply the decoded operation to A and B
    always_comb begin
        Out = '0;
        case (alu_op)
            ALU_ADD:    Out = A + B;
            ALU_SUB:    Out = A - B;
            ALU_AND:    Out = A & B;
            ALU_OR:     Out = A | B;
            ALU_XOR:    Out = A ^ B;
            ALU_SLT:    Out = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU:   Out = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_SLL:    Out = A << shamt;
            ALU_SRA:    Out = XLEN'($signed(A) >>> shamt);
            ALU_SRL:    Out = A >> shamt;
            ALU_COPY_B: Out = B;
            default:    Out = '0;
        endcase
    end

    // Next value of the registered result: capture when enabled, else hold
    always_comb begin
        result_d = en ? Out : result_q;
    end

    // Registered result for the next pipeline stage
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign Out_q = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus randomized
// traffic compared against a behavioural reference model.
module tb_alu_core;

    logic        Clock;
    logic        Reset;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic        en;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] Out_q;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_q;

    alu_core dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .en              (en),
        .ALUop           (ALUop),
        .Out             (Out),
        .Out_q           (Out_q)
    );

    // clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // reference: opcode/funct/bit30 -> operation code
    function automatic logic [3:0] model_op(input logic [6:0] opc, input logic [2:0] f, input logic b30);
        logic [3:0] op_table [8];
        op_table = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2};
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            if (f == 3'd0) return (opc == 7'b0110011 && b30) ? 4'd1 : 4'd0;
            if (f == 3'd5) return b30 ? 4'd8 : 4'd9;
            return op_table[f];
        end
        if (opc == 7'b0110111) return 4'd10;
        if (opc == 7'b0010111 || opc == 7'b1101111 || opc == 7'b1100111 ||
            opc == 7'b1100011 || opc == 7'b0000011 || opc == 7'b0100011) return 4'd0;
        return 4'd15;
    endfunction

    // reference: operation applied with plain arithmetic
    function automatic logic [31:0] model_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        longint unsigned wide;
        logic [31:0] ones;
        s = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd7: begin
                wide = longint'(a) * (64'd1 << s);
                return wide[31:0];
            end
            4'd8:  return (a / (32'd1 << s)) | (a[31] ? ~(ones >> s) : 32'd0);
            4'd9:  return a / (32'd1 << s);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // driver: set combinational inputs
    task automatic drive(input logic [6:0] opc, input logic [2:0] f, input logic b30,
                         input logic [31:0] a, input logic [31:0] b);
        opcode = opc;
        funct = f;
        add_rshift_type = b30;
        A = a;
        B = b;
    endtask

    // directed: drive, settle, compare to given constants
    task automatic direct(input string tag, input logic [6:0] opc, input logic [2:0] f, input logic b30,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_out);
        drive(opc, f, b30, a, b);
        #1;
        check(tag, Out, exp_out);
    endtask

    logic [6:0] opc_pool [10];

    initial begin
        opc_pool = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                     7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1111111};

        // reset
        Reset = 1'b1;
        en = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge Clock);
        #1;
        check("reset_out_q", Out_q, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // directed combinational cases
        direct("r_add", 7'b0110011, 3'b000, 1'b0, 32'h5, 32'h7, 32'h0000_000C);
        direct("r_sub", 7'b0110011, 3'b000, 1'b1, 32'h5, 32'h7, 32'hFFFF_FFFE);
        direct("i_add", 7'b0010011, 3'b000, 1'b1, 32'h1, 32'h2, 32'h0000_0003);
        check("i_add_op", {28'd0, ALUop}, 32'd0);
        direct("sll", 7'b0110011, 3'b001, 1'b0, 32'h8000_0010, 32'hFFFF_FFE4, 32'h0000_0100);
        direct("srl", 7'b0110011, 3'b101, 1'b0, 32'h8000_0010, 32'hFFFF_FFE4, 32'h0800_0001);
        direct("sra", 7'b0110011, 3'b101, 1'b1, 32'h8000_0010, 32'hFFFF_FFE4, 32'hF800_0001);
        direct("srai", 7'b0010011, 3'b101, 1'b1, 32'h8000_0010, 32'h0000_0404, 32'hF800_0001);
        direct("slt", 7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1);
        direct("sltu", 7'b0110011, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        direct("lui", 7'b0110111, 3'b000, 1'b0, 32'h1234, 32'hABCD_E000, 32'hABCD_E000);
        direct("store", 7'b0100011, 3'b010, 1'b1, 32'h100, 32'h8, 32'h0000_0108);
        direct("unknown", 7'b1111111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h0);
        check("unknown_op", {28'd0, ALUop}, 32'd15);

        // register: capture, hold, async reset
        @(negedge Clock);
        drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4);
        en = 1'b1;
        @(posedge Clock);
        #1;
        check("reg_capture", Out_q, 32'd7);
        @(negedge Clock);
        en = 1'b0;
        drive(7'b0110011, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0);
        @(posedge Clock);
        #1;
        check("reg_hold", Out_q, 32'd7);
        #2;
        Reset = 1'b1;
        #1;
        check("reg_async_reset", Out_q, 32'd0);
        @(negedge Clock);
        en = 1'b1;
        @(posedge Clock);
        #1;
        check("reg_reset_wins", Out_q, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        model_q = 32'd0;

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [6:0]  r_opc;
            logic [31:0] r_a;
            logic [31:0] r_b;
            logic [3:0]  eop;
            logic [31:0] eout;
            @(negedge Clock);
            r_opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : opc_pool[$urandom_range(0, 9)];
            r_a = $urandom;
            r_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            drive(r_opc, 3'($urandom), 1'($urandom), r_a, r_b);
            en = ($urandom_range(0, 2) != 0);
            #1;
            eop = model_op(opcode, funct, add_rshift_type);
            eout = model_out(eop, A, B);
            check("rand_op", {28'd0, ALUop}, {28'd0, eop});
            check("rand_out", Out, eout);
            if ($urandom_range(0, 24) == 0) begin
                Reset = 1'b1;
                #1;
                model_q = 32'd0;
                check("rand_async_reset", Out_q, 32'd0);
                #1;
                Reset = 1'b0;
            end
            if (en) model_q = eout;
            exp_q.push_back(model_q);
            @(posedge Clock);
            #1;
            check("rand_out_q", Out_q, exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
